// File: rtl/bram_burst_arbiter.sv
// ============================================================================
// bram_burst_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares one BRAM port between two line-burst requesters.
//     req0 = dcache refill/writeback
//     req1 = icache refill/loader
//   One requester is granted at a time. For that requester the block issues
//   LINE_WORDS consecutive word accesses (all reads or all writes) to the
//   BRAM port.
//
// Bursts:
//   Each burst covers one aligned line. The base address is the request
//   address with the low log2(LINE_WORDS) bits cleared.
//
//   Read burst:  IDLE(accept) -> RBURST x LINE_WORDS -> RDRAIN -> IDLE
//                The extra RDRAIN cycle collects the last read word, because
//                the BRAM has one cycle of read latency.
//   Write burst: IDLE(accept) -> WBURST x LINE_WORDS -> IDLE
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   req_valid    [1:0] per-requester burst request, held until req_ready
//   req_write    [1:0] 1 = write burst, 0 = read burst
//   req_addr     [2*ADDR_WIDTH-1:0] word address of requester i, in slice i
//   req_wdata    [2*DATA_WIDTH-1:0] current write word of requester i
//   req_ready    [1:0] one-cycle grant pulse
//   wdata_pop    [1:0] current write word consumed this cycle
//   rdata        read data; this is mem_dout passed straight through
//   rvalid       [1:0] rdata is valid for requester i
//   done         [1:0] one-cycle burst-complete pulse
//   mem_en, mem_we, mem_addr, mem_din   BRAM port controls
//   mem_dout     BRAM read data, one cycle of latency
//
// Configuration macro:
//   ARB_FIXED_PRIORITY_EN
//     Defined:   req0 always wins when both requesters are valid
//                (req1 may starve).
//     Undefined: round-robin arbitration that remembers the last grant.
// ============================================================================
module bram_burst_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              wdata_pop,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rvalid,
  output logic [1:0]              done,
  output logic                    mem_en,
  output logic [NUM_COL-1:0]      mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);

  localparam int CNT_W = $clog2(LINE_WORDS);

  // Value of the word counter on the last word of a line.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  // Clears the in-line word offset from a request address.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RBURST = 2'd1,
    RDRAIN = 2'd2,
    WBURST = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   base_q,  base_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;

  // Per-cycle strobes decoded from the FSM.
  logic                    accept;
  logic                    rd_issue;
  logic                    wr_issue;
  logic                    rd_valid;
  logic                    burst_done;
  logic                    arb_sel;

  // Per-requester views of the packed address and write-data buses.
  logic [ADDR_WIDTH-1:0]   addr_a  [2];
  logic [DATA_WIDTH-1:0]   wdata_a [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign addr_a[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_a[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  // arb_sel is only used when at least one requester is valid.
  // If only one requester is valid, it wins.
`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    arb_sel = ~req_valid[0];  // req0 wins whenever it is present
  end
`else
  logic last_grant_q;

  always_comb begin
    if (&req_valid) begin
      arb_sel = ~last_grant_q;  // both valid: the other one's turn
    end else begin
      arb_sel = ~req_valid[0];
    end
  end

  // last_grant resets to 1, so the first two-way contention goes to req0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= arb_sel;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // FSM: next state and strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    rd_issue   = 1'b0;
    wr_issue   = 1'b0;
    rd_valid   = 1'b0;
    burst_done = 1'b0;

    case (state_q)
      IDLE: begin
        // Do not grant while reset is asserted. The grant would be
        // discarded by the reset, but the requester would see a real pulse.
        if ((|req_valid) && !rst) begin
          accept  = 1'b1;
          grant_d = arb_sel;
          base_d  = addr_a[arb_sel] & LINE_MASK;
          cnt_d   = '0;
          state_d = req_write[arb_sel] ? WBURST : RBURST;
        end
      end

      RBURST: begin
        rd_issue = 1'b1;
        // The word issued in the previous cycle is on mem_dout now.
        rd_valid = (cnt_q != '0);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = RDRAIN;
        end
      end

      RDRAIN: begin
        // Last read word arrives; the burst is complete.
        rd_valid   = 1'b1;
        burst_done = 1'b1;
        state_d    = IDLE;
      end

      WBURST: begin
        wr_issue = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          burst_done = 1'b1;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // BRAM port
  // --------------------------------------------------------------------------
  // The counter only fills the cleared low bits of the base, so OR-ing it in
  // can never carry into the line address.
  // Address and data are forced to zero outside bursts so the port is quiet.
  assign mem_en   = rd_issue | wr_issue;
  assign mem_we   = {NUM_COL{wr_issue}};
  assign mem_addr = mem_en ? (base_q | ADDR_WIDTH'(cnt_q)) : '0;
  assign mem_din  = wr_issue ? wdata_a[grant_q] : '0;
  assign rdata    = mem_dout;

  // --------------------------------------------------------------------------
  // Per-requester handshakes
  // --------------------------------------------------------------------------
  // These signals are only asserted for the requester that holds the grant.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic is_owner;
      assign is_owner       = (grant_q == 1'(gi));
      assign req_ready[gi]  = accept & (arb_sel == 1'(gi));
      assign wdata_pop[gi]  = wr_issue & is_owner;
      assign rvalid[gi]     = rd_valid & is_owner;
      assign done[gi]       = burst_done & is_owner;
    end
  endgenerate

endmodule

// File: tb/tb_bram_burst_arbiter.sv
module tb_bram_burst_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int NC = 4;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_ready;
  logic [1:0]      wdata_pop;
  logic [DW-1:0]   rdata;
  logic [1:0]      rvalid;
  logic [1:0]      done;
  logic            mem_en;
  logic [NC-1:0]   mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_din;
  logic [DW-1:0]   mem_dout;

  int total = 0;
  int bad   = 0;
  int nburst = 0;

  // Reference model state.
  // ref_last is the requester that was granted most recently.
  // ref_mem/ref_w hold the expected BRAM contents.
  int          ref_last = 1;
  logic [31:0] ref_mem [2048];
  bit          ref_w   [2048];

  // Behavioural BRAM: read-first, one cycle of latency, byte enables.
  logic [31:0] bram   [2048];
  bit          bram_w [2048];

  bram_burst_arbiter #(
    .ADDR_WIDTH(AW),
    .NUM_COL   (NC),
    .COL_WIDTH (8),
    .DATA_WIDTH(DW),
    .LINE_WORDS(LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .wdata_pop(wdata_pop),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .done     (done),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  // Initial contents of any BRAM word that has never been written.
  function automatic logic [31:0] init_word(input logic [10:0] a);
    return 32'hC0DE_0000 ^ ({21'b0, a} * 32'h9E37_79B1);
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    return ref_w[a] ? ref_mem[a] : init_word(11'(a));
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      logic [31:0] cur;
      cur = bram_w[mem_addr] ? bram[mem_addr] : init_word(mem_addr);
      mem_dout <= cur;
      if (|mem_we) begin
        for (int b = 0; b < NC; b++) begin
          if (mem_we[b]) begin
            cur[8*b +: 8] = mem_din[8*b +: 8];
          end
        end
        bram[mem_addr]   <= cur;
        bram_w[mem_addr] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_pop"},   64'(wdata_pop), 64'(0));
    check({tag, "_rvalid"},64'(rvalid),    64'(0));
    check({tag, "_done"},  64'(done),      64'(0));
    check({tag, "_en"},    64'(mem_en),    64'(0));
    check({tag, "_we"},    64'(mem_we),    64'(0));
    check({tag, "_addr"},  64'(mem_addr),  64'(0));
    check({tag, "_din"},   64'(mem_din),   64'(0));
  endtask

  // Waits a bounded number of cycles for any grant; returns at that negedge.
  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    check("grant_seen", 64'(got), 64'(1));
  endtask

  // Serves one burst from the currently driven requests.
  //   keep:   if 1, the requests stay asserted after the grant.
  //   glitch: if >= 0, req1 is pulsed for one cycle at that word offset.
  task automatic serve(input int glitch, input bit keep);
    int          exp_g;
    int          base;
    bit          wr;
    bit          got;
    int          ncyc;
    logic [1:0]  gbit;
    logic [31:0] wq [LW];

    // Predict the grant from the arbitration rules.
    if (req_valid == 2'b11) begin
`ifdef ARB_FIXED_PRIORITY_EN
      exp_g = 0;
`else
      exp_g = (ref_last == 1) ? 0 : 1;
`endif
    end else begin
      exp_g = req_valid[1] ? 1 : 0;
    end

    wait_grant(got);
    if (!got) return;

    gbit = 2'(1 << exp_g);
    check("req_ready", 64'(req_ready), 64'(gbit));
    ref_last = exp_g;
    wr   = req_write[exp_g];
    base = int'(req_addr[exp_g*AW +: AW]) & ~(LW - 1);
    for (int k = 0; k < LW; k++) begin
      wq[k] = $urandom;
    end
    if (wr) begin
      req_wdata[exp_g*DW +: DW] = wq[0];
    end
    nburst++;
    $display("burst %0d: req%0d %s line 0x%03h", nburst, exp_g, wr ? "write" : "read", base);

    @(posedge clk); #1;
    if (!keep) begin
      req_valid = 2'b00;
    end

    ncyc = wr ? LW : LW + 1;
    for (int k = 0; k < ncyc; k++) begin
      if (glitch >= 0 && k == glitch) req_valid[1] = 1'b1;
      if (glitch >= 0 && k == glitch + 1) req_valid[1] = 1'b0;
      @(negedge clk);
      check("ready_in_burst", 64'(req_ready), 64'(0));
      if (wr) begin
        check("w_en",   64'(mem_en),    64'(1));
        check("w_we",   64'(mem_we),    64'(4'hF));
        check("w_addr", 64'(mem_addr),  64'(base + k));
        check("w_din",  64'(mem_din),   64'(wq[k]));
        check("w_pop",  64'(wdata_pop), 64'(gbit));
        check("w_rvld", 64'(rvalid),    64'(0));
        check("w_done", 64'(done),      64'((k == LW - 1) ? gbit : 2'b00));
      end else begin
        check("r_en",   64'(mem_en),    64'((k < LW) ? 1 : 0));
        check("r_we",   64'(mem_we),    64'(0));
        check("r_addr", 64'(mem_addr),  64'((k < LW) ? base + k : 0));
        check("r_pop",  64'(wdata_pop), 64'(0));
        check("r_rvld", 64'(rvalid),    64'((k >= 1) ? gbit : 2'b00));
        if (k >= 1) begin
          check("r_data", 64'(rdata), 64'(ref_word(base + k - 1)));
        end
        check("r_done", 64'(done),      64'((k == LW) ? gbit : 2'b00));
      end
      @(posedge clk); #1;
      if (wr && k + 1 < LW) begin
        req_wdata[exp_g*DW +: DW] = wq[k+1];
      end
    end

    if (wr) begin
      for (int k = 0; k < LW; k++) begin
        ref_mem[base + k] = wq[k];
        ref_w[base + k]   = 1'b1;
      end
    end
  endtask

  initial begin
    bit got;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state, both while reset is held and just after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle");
    @(posedge clk); #1;

    // req0 read of line 0x010.
    req_valid = 2'b01; req_write = 2'b00; req_addr = {11'h000, 11'h010};
    serve(-1, 1'b0);

    // req1 write at 0x023 (line 0x020), then read the line back via req0.
    req_valid = 2'b10; req_write = 2'b10; req_addr = {11'h023, 11'h000};
    serve(-1, 1'b0);
    req_valid = 2'b01; req_write = 2'b00; req_addr = {11'h000, 11'h020};
    serve(-1, 1'b0);

    // req1 pulses for one cycle during a req0 burst; it must not be granted.
    req_valid = 2'b01; req_write = 2'b00; req_addr = {11'h030, 11'h024};
    serve(1, 1'b0);
    @(negedge clk);
    check("glitch_no_ready", 64'(req_ready), 64'(0));
    check("glitch_idle_en",  64'(mem_en),    64'(0));
    @(posedge clk); #1;

    // Reset asserted two cycles into a req0 read.
    req_valid = 2'b01; req_write = 2'b00; req_addr = {11'h000, 11'h040};
    wait_grant(got);
    check("rst_grant", 64'(req_ready), 64'(2'b01));
    @(posedge clk); #1;      // T+1
    req_valid = 2'b00;
    @(posedge clk); #1;      // T+2
    rst = 1'b1;
    @(negedge clk);
    check("rst_pre_rvalid", 64'(rvalid), 64'(2'b01));
    @(posedge clk); #1;      // T+3
    rst = 1'b0;
    ref_last = 1;
    @(negedge clk);
    check_quiet("midrst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_no_done", 64'(done), 64'(0));
    end
    @(posedge clk); #1;
    req_valid = 2'b10; req_write = 2'b00; req_addr = {11'h041, 11'h000};
    serve(-1, 1'b0);

    // Both requesters held valid: grants follow the arbitration policy.
    req_valid = 2'b11; req_write = 2'b10; req_addr = {11'h205, 11'h100};
    for (int i = 0; i < 6; i++) begin
      serve(-1, (i < 5));
    end

    // Random mixes of requesters, directions and addresses.
    for (int i = 0; i < 16; i++) begin
      req_valid = 2'($urandom_range(1, 3));
      req_write = 2'($urandom);
      req_addr  = {11'($urandom_range(0, 63)), 11'($urandom_range(0, 63))};
      serve(-1, 1'b0);
    end

    @(negedge clk);
    check("final_idle_en", 64'(mem_en), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
